sram_1rw_init_ext: RTL and testbench
====================================

# sram_1rw_init_ext

Parametrised single-port (1RW) SRAM model with masked writes, a configurable mask granularity, and a hardware initialisation sweep after reset. It replaces the fixed-size `*_ext` array models used under the BPU predictor tables, such as the 256x16 tables. Instead of relying on simulation-only random init, it writes `INIT_VAL` to every entry after reset and signals readiness. Predictor logic can then treat table contents as defined from the first lookup.

## Interface
- `ADDR_W`, 8: address width; depth `DEPTH = 2**ADDR_W`.
- `DATA_W`, 16: entry width.
- `MASK_W`, 16: write-mask width; granule `G = DATA_W/MASK_W`.
- `INIT_VAL`, 0: `DATA_W`-bit value written to every entry during the init sweep.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `RW0_addr` in `ADDR_W`: access address.
- `RW0_en` in 1: access request.
- `RW0_wmode` in 1: 1 = write, 0 = read.
- `RW0_wmask` in `MASK_W`: bit i enables data bits `[i*G +: G]`.
- `RW0_wdata` in `DATA_W`: write data.
- `RW0_rdata` out `DATA_W`: read data.
- `RW0_rvalid` out 1: 1-cycle pulse; `RW0_rdata` carries a new read result.
- `RW0_ready` out 1: init sweep complete; requests are accepted.

## Operation
- FSM states:
  - INIT: reset state. Counter `cnt` (`ADDR_W+1` bits) starts at 0. Each cycle it writes `INIT_VAL` to `ram[cnt]`, then `cnt++`. When `cnt == DEPTH-1` is written, the FSM goes to READY. No other transitions.
  - READY: normal service. Leaves only via `reset`.
- In INIT, `RW0_ready=0` and `RW0_en` is ignored: no write, no read, no `rvalid`.
- READY write (`en & wmode`): per granule i, `ram[addr]` granule ← `wdata` granule if `wmask[i]`, else unchanged. A write never changes `RW0_rdata` and never pulses `rvalid`.
- READY read (`en & ~wmode`): `ram[addr]` is captured into a data register, and `rvalid` pulses. `RW0_rdata` holds the last read value until the next read; it does not follow later writes to the same address.
- `wmask == 0` write: a legal no-op access.
- Elaboration error if `DATA_W % MASK_W != 0`.
- Reset values: `RW0_rdata=0`, `RW0_rvalid=0`, `RW0_ready=0`, state INIT, `cnt=0`. Array contents are not reset directly; the sweep defines them.
- Reset asserted mid-sweep or mid-READY: outputs clear immediately (async), and the sweep restarts from address 0 after deassertion. Any in-flight read result is discarded.

## Timing
- Init: first rising edge after `reset` deasserts writes entry 0. `RW0_ready` rises after edge `DEPTH` (256 cycles at defaults) and is registered.
- Read latency 1 (default build): request sampled at edge N; `rdata`/`rvalid` valid after edge N.
- Write takes effect at the sampling edge. A read of the same address at the next edge returns the new data.
- Back-to-back reads at 1/cycle give an `rvalid` every cycle.
- `RW0_ready` may be sampled combinationally by the requester; a request presented in the first READY cycle is accepted.

## Configuration
- `SRAM_OUTREG_EN` defined: an extra output register stage is added. `RW0_rdata` and `RW0_rvalid` appear one edge later (read latency 2). A read pipelined behind another read still sustains 1/cycle. The write-then-read-same-address rule is unchanged. Reset clears both stages.
- Not defined: latency 1, single register.

## Test plan
- Reset release at defaults -> `RW0_ready=0` for 256 cycles, then 1. Reads of addr 0x00, 0x7F and 0xFF return 0x0000 with `rvalid` one cycle after each request.
- Write 0x00FF to addr 0x10 with mask 0x00F0, then read 0x10 -> `rdata=0x00F0`. Write 0xAB00 with mask 0xFF00, then read -> `0xABF0`.
- `MASK_W=2`, `DATA_W=16`: write 0x1234 with mask 2'b01 to a zeroed entry -> read returns 0x0034.
- Read addr 5 (0x1111), then write 0x2222 to addr 5 the next cycle -> `rdata` stays 0x1111 and `rvalid` pulses once. The following read returns 0x2222.
- Assert `reset` at sweep cycle 100 for 1 cycle -> `ready=0` immediately. Sweep restarts: `ready` rises 256 cycles after deassert. Requests presented during INIT produce no `rvalid` and no array change.
- With `SRAM_OUTREG_EN`: reads to 1, 2, 3 on consecutive cycles -> `rvalid` on the 3 cycles starting 2 edges after the first request, data in order.

Source files
------------

// File: rtl/sram_1rw_init_ext.sv
// Single-port SRAM model with masked writes and a post-reset init sweep that writes INIT_VAL everywhere.
// Optional macro SRAM_OUTREG_EN adds a second read-output register stage (read latency 2).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | sweep writes INIT_VAL to ram[cnt] each cycle; requests ignored
// ST_READY | normal read / masked-write service until the next reset
module sram_1rw_init_ext #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int MASK_W = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [MASK_W-1:0] RW0_wmask,
  input  logic [DATA_W-1:0] RW0_wdata,
  output logic [DATA_W-1:0] RW0_rdata,
  output logic              RW0_rvalid,
  output logic              RW0_ready
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int G     = DATA_W / MASK_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);

  generate
    if (DATA_W % MASK_W != 0) begin : g_bad_mask
      $error("sram_1rw_init_ext: DATA_W must be a multiple of MASK_W");
    end
  endgenerate

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              init_we, acc_rd, acc_wr;
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic              rv_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_we   = 1'b0;
    acc_rd    = 1'b0;
    acc_wr    = 1'b0;
    case (state)
      ST_INIT: begin
        init_we = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_IDX) state_nxt = ST_READY;
      end
      ST_READY: begin
        acc_rd = RW0_en & ~RW0_wmode;
        acc_wr = RW0_en &  RW0_wmode;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Array has no reset; the sweep is what defines its contents.
  always_ff @(posedge clock) begin
    if (init_we) begin
      ram[cnt[ADDR_W-1:0]] <= INIT_VAL;
    end else if (acc_wr) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (RW0_wmask[i]) ram[RW0_addr][i*G +: G] <= RW0_wdata[i*G +: G];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= acc_rd;
      if (acc_rd) rd_q <= ram[RW0_addr];
    end
  end

`ifdef SRAM_OUTREG_EN
  logic [DATA_W-1:0] rd_q2;
  logic              rv_q2;

  // Second stage only reloads on a valid result so rdata still holds between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q2 <= '0;
      rv_q2 <= 1'b0;
    end else begin
      rv_q2 <= rv_q;
      if (rv_q) rd_q2 <= rd_q;
    end
  end

  assign RW0_rdata  = rd_q2;
  assign RW0_rvalid = rv_q2;
`else
  assign RW0_rdata  = rd_q;
  assign RW0_rvalid = rv_q;
`endif

  assign RW0_ready = (state == ST_READY);

endmodule

// File: tb/tb_sram_1rw_init_ext.sv
// Self-checking bench for sram_1rw_init_ext: vector table, hand sequences and random traffic
// against an array-based reference model; a second small instance covers MASK_W=2.
module tb_sram_1rw_init_ext;

`ifdef SRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rw_addr = '0;
  logic        rw_en = 1'b0;
  logic        rw_wmode = 1'b0;
  logic [15:0] rw_wmask = '0;
  logic [15:0] rw_wdata = '0;
  logic [15:0] rw_rdata;
  logic        rw_rvalid;
  logic        rw_ready;

  logic        r2 = 1'b1;
  logic [3:0]  a2 = '0;
  logic        en2 = 1'b0;
  logic        wm2 = 1'b0;
  logic [1:0]  m2 = '0;
  logic [15:0] d2 = '0;
  logic [15:0] q2;
  logic        v2;
  logic        rdy2;

  always #5 clock = ~clock;

  sram_1rw_init_ext dut (
    .clock(clock), .reset(reset), .RW0_addr(rw_addr), .RW0_en(rw_en),
    .RW0_wmode(rw_wmode), .RW0_wmask(rw_wmask), .RW0_wdata(rw_wdata),
    .RW0_rdata(rw_rdata), .RW0_rvalid(rw_rvalid), .RW0_ready(rw_ready)
  );

  sram_1rw_init_ext #(.ADDR_W(4), .DATA_W(16), .MASK_W(2)) dut2 (
    .clock(clock), .reset(r2), .RW0_addr(a2), .RW0_en(en2),
    .RW0_wmode(wm2), .RW0_wmask(m2), .RW0_wdata(d2),
    .RW0_rdata(q2), .RW0_rvalid(v2), .RW0_ready(rdy2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents, edges since reset, and the result pipeline.
  logic [15:0] mdl [DEPTH];
  int          since_rst = 0;
  logic        pv [2];
  logic [15:0] pd [2];
  logic [15:0] exp_rdata = '0;
  int          rv_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    since_rst = 0;
    exp_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      pv[k] = 1'b0;
      pd[k] = '0;
    end
  endtask

  // One clock: present a request, let the edge happen, then compare against the model.
  task automatic step(input logic en, input logic wm, input logic [7:0] a,
                      input logic [15:0] m, input logic [15:0] d);
    logic        rv;
    logic [15:0] rd;
    rw_en = en; rw_wmode = wm; rw_addr = a; rw_wmask = m; rw_wdata = d;
    @(posedge clock);
    #1;
    rv = 1'b0;
    rd = '0;
    if (since_rst < DEPTH) begin
      mdl[since_rst] = 16'h0000;
    end else if (en) begin
      if (wm) mdl[a] = (mdl[a] & ~m) | (d & m);
      else begin
        rv = 1'b1;
        rd = mdl[a];
      end
    end
    since_rst++;
    for (int k = LAT-1; k > 0; k--) begin
      pv[k] = pv[k-1];
      pd[k] = pd[k-1];
    end
    pv[0] = rv;
    pd[0] = rd;
    if (pv[LAT-1]) exp_rdata = pd[LAT-1];
    if (rw_rvalid) rv_seen++;
    chk("ready", 32'(rw_ready), 32'(since_rst >= DEPTH));
    chk("rvalid", 32'(rw_rvalid), 32'(pv[LAT-1]));
    chk("rdata", 32'(rw_rdata), 32'(exp_rdata));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000);
  endtask

  // Assert reset mid-cycle, check the async clear, hold across one edge, release.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(rw_ready), 32'd0);
    chk({tag, "_rvalid"}, 32'(rw_rvalid), 32'd0);
    chk({tag, "_rdata"}, 32'(rw_rdata), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic sweep_random(input int n);
    for (int i = 0; i < n; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           16'($urandom), 16'($urandom));
  endtask

  typedef struct {
    logic        wm;
    logic [7:0]  a;
    logic [15:0] m;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t tab [10];

  initial begin
    int n;
    model_clear();
    tab[0] = '{1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000};
    tab[1] = '{1'b0, 8'h7F, 16'h0000, 16'h0000, 16'h0000};
    tab[2] = '{1'b0, 8'hFF, 16'h0000, 16'h0000, 16'h0000};
    tab[3] = '{1'b1, 8'h10, 16'h00F0, 16'h00FF, 16'h0000};
    tab[4] = '{1'b0, 8'h10, 16'h0000, 16'h0000, 16'h00F0};
    tab[5] = '{1'b1, 8'h10, 16'hFF00, 16'hAB00, 16'h0000};
    tab[6] = '{1'b0, 8'h10, 16'h0000, 16'h0000, 16'hABF0};
    tab[7] = '{1'b1, 8'h10, 16'h0000, 16'hFFFF, 16'h0000};
    tab[8] = '{1'b0, 8'h10, 16'h0000, 16'h0000, 16'hABF0};
    tab[9] = '{1'b1, 8'h05, 16'hFFFF, 16'h1111, 16'h0000};

    do_reset("rst0");
    sweep_random(DEPTH);

    for (int i = 0; i < 10; i++) begin
      step(1'b1, tab[i].wm, tab[i].a, tab[i].m, tab[i].d);
      if (!tab[i].wm) begin
        for (int k = 1; k < LAT; k++) idle();
        chk($sformatf("tab%0d_rvalid", i), 32'(rw_rvalid), 32'd1);
        chk($sformatf("tab%0d_rdata", i), 32'(rw_rdata), 32'(tab[i].exp));
      end
    end

    // Read then immediately overwrite the same entry: held data must not follow the write.
    rv_seen = 0;
    step(1'b1, 1'b0, 8'h05, 16'h0000, 16'h0000);
    step(1'b1, 1'b1, 8'h05, 16'hFFFF, 16'h2222);
    idle();
    idle();
    chk("hold_rdata", 32'(rw_rdata), 32'h1111);
    chk("hold_pulses", 32'(rv_seen), 32'd1);
    step(1'b1, 1'b0, 8'h05, 16'h0000, 16'h0000);
    for (int k = 1; k < LAT; k++) idle();
    chk("reread_rdata", 32'(rw_rdata), 32'h2222);

    // Back-to-back reads of 1, 2, 3.
    step(1'b1, 1'b1, 8'h01, 16'hFFFF, 16'hA001);
    step(1'b1, 1'b1, 8'h02, 16'hFFFF, 16'hA002);
    step(1'b1, 1'b1, 8'h03, 16'hFFFF, 16'hA003);
    rv_seen = 0;
    step(1'b1, 1'b0, 8'h01, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 8'h02, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 8'h03, 16'h0000, 16'h0000);
    for (int k = 0; k < LAT; k++) idle();
    chk("b2b_pulses", 32'(rv_seen), 32'd3);

    // Random traffic over a narrow address window to force collisions.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));

    // Reset during READY right after a read, then again at sweep cycle 100.
    step(1'b1, 1'b1, 8'h20, 16'hFFFF, 16'h5A5A);
    step(1'b1, 1'b0, 8'h20, 16'h0000, 16'h0000);
    do_reset("rst_ready");
    sweep_random(100);
    do_reset("rst_sweep");
    sweep_random(DEPTH);
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, 8'($urandom), 16'h0000, 16'h0000);
    for (int k = 0; k < LAT; k++) idle();

    // MASK_W=2 instance: granule 0 is the low byte.
    #2 r2 = 1'b0;
    n = 0;
    while (!rdy2 && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("m2_ready_cycles", 32'(n), 32'd16);
    a2 = 4'd3; en2 = 1'b1; wm2 = 1'b1; m2 = 2'b01; d2 = 16'h1234;
    @(posedge clock);
    #1 wm2 = 1'b0;
    @(posedge clock);
    #1 en2 = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      @(posedge clock);
      #1;
    end
    chk("m2_rvalid", 32'(v2), 32'd1);
    chk("m2_rdata", 32'(q2), 32'h0034);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
